// File: rtl/alu_stack_pkg.sv
// Shared encodings for the stack processor execute-stage sequencer.
// Command types, ALU opcodes and sequencer states live here.
package alu_stack_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;

    typedef enum logic [1:0] {
        CMD_PUSH = 2'd0,
        CMD_POP  = 2'd1,
        CMD_ALU  = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_type_e;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_A    = 4'd5;
    localparam logic [OP_W-1:0] OP_B    = 4'd6;
    localparam logic [OP_W-1:0] OP_NEQ  = 4'd7;
    localparam logic [OP_W-1:0] OP_ANZ  = 4'd8;
    localparam logic [OP_W-1:0] OP_BLTA = 4'd9;
    localparam logic [OP_W-1:0] OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_e;

    function automatic logic op_legal(
        input logic [OP_W-1:0] op
    );
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_stack_ctrl_alu.sv
// Shared 16-bit ALU; purely combinational, fed from operand registers.
// Overflow is the add carry-out and reads 0 for every other opcode.
module alu
    import alu_stack_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                y   = sum[DATA_W-1:0];
                ovf = sum[DATA_W];
            end
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_A:    y = a;
            OP_B:    y = b;
            OP_NEQ:  y = DATA_W'(a != b);
            OP_ANZ:  y = DATA_W'(a != '0);
            OP_BLTA: y = DATA_W'(b < a);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_stack_ctrl.sv
// Execute-stage sequencer owning the operand stack and the shared ALU.
// One command in flight; PUSH/POP/errors answer in 1 cycle, ALU in 3.
module alu_stack_ctrl
    import alu_stack_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic [DATA_W-1:0] tos,
    output logic [PTR_W-1:0]  depth
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state;
    state_e            state_nxt;
    logic [DATA_W-1:0] stack [DEPTH];
    logic [PTR_W-1:0]  cnt;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] alu_y;
    logic              alu_ovf;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  nxt_idx;
    logic [IDX_W-1:0]  push_idx;
    logic              accept;
    logic              is_push;
    logic              is_pop;
    logic              is_alu;
    logic              cmd_err;

    assign top_idx  = IDX_W'(cnt - PTR_W'(1));
    assign nxt_idx  = IDX_W'(cnt - PTR_W'(2));
    assign push_idx = IDX_W'(cnt);

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign depth     = cnt;
    assign tos       = (cnt == '0) ? '0 : stack[top_idx];

    assign is_push = (cmd_type == CMD_PUSH);
    assign is_pop  = (cmd_type == CMD_POP);
    assign is_alu  = (cmd_type == CMD_ALU);

    // Everything rejectable is known at acceptance, so errors never stall.
    assign cmd_err =
        (is_push && cnt == PTR_W'(DEPTH)) ||
        (is_pop && cnt == '0) ||
        (is_alu && (cnt < PTR_W'(2) || !op_legal(cmd_op))) ||
        (cmd_type == CMD_RSVD);

    alu u_alu (
        .op  (op_q),
        .a   (opa_q),
        .b   (opb_q),
        .y   (alu_y),
        .ovf (alu_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (cmd_valid)
                state_nxt = (is_alu && !cmd_err) ? READ : RESP;
            READ: state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            op_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    op_q <= cmd_op;
                    if (cmd_err) begin
                        rsp_valid    <= 1'b1;
                        rsp_data     <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b1;
                    end else if (is_push) begin
                        cnt          <= cnt + PTR_W'(1);
                        rsp_valid    <= 1'b1;
                        rsp_data     <= cmd_data;
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b0;
                    end else if (is_pop) begin
                        cnt          <= cnt - PTR_W'(1);
                        rsp_valid    <= 1'b1;
                        rsp_data     <= stack[top_idx];
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b0;
                    end
                end
                READ: begin
                    opa_q <= stack[nxt_idx];
                    opb_q <= stack[top_idx];
                end
                EXEC: begin
                    cnt          <= cnt - PTR_W'(1);
                    rsp_valid    <= 1'b1;
                    rsp_data     <= alu_y;
                    rsp_overflow <= alu_ovf;
                    rsp_err      <= 1'b0;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
            endcase
        end
    end

    // Contents need no reset: depth alone decides what is visible.
    always_ff @(posedge clk) begin
        if (reset_n && accept && !cmd_err && is_push)
            stack[push_idx] <= cmd_data;
        else if (reset_n && state == EXEC)
            stack[nxt_idx] <= alu_y;
    end

endmodule

// File: tb/tb_alu_stack_ctrl.sv
// Self-checking bench for alu_stack_ctrl: vector table, random stream
// against a queue-based stack model, and hand-written corner sequences.
module tb_alu_stack_ctrl;

    localparam int DEPTH = 16;
    localparam int PTR_W = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [3:0]        cmd_op;
    logic [15:0]       cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic              rsp_overflow;
    logic              rsp_err;
    logic [15:0]       tos;
    logic [PTR_W-1:0]  depth;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] model [$];

    typedef struct {
        logic [1:0]  t;
        logic [3:0]  op;
        logic [15:0] d;
        logic [15:0] e_data;
        logic        e_err;
        logic        e_ovf;
        int          e_depth;
    } vec_t;

    vec_t tbl [$];

    alu_stack_ctrl #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err),
        .tos          (tos),
        .depth        (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_tos();
        return (model.size() == 0) ? 16'h0 : model[model.size()-1];
    endfunction

    task automatic ref_alu(input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, output logic [15:0] r,
                           output logic o);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        o  = 1'b0;
        case (op)
            0: begin
                r = 16'((ai + bi) % 65536);
                o = (ai + bi) > 65535;
            end
            1: r = 16'((ai - bi + 65536) % 65536);
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a;
            6: r = b;
            7: r = (ai != bi) ? 16'd1 : 16'd0;
            8: r = (ai != 0)  ? 16'd1 : 16'd0;
            9: r = (bi < ai)  ? 16'd1 : 16'd0;
            default: r = 16'h0;
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [3:0] op,
                           input logic [15:0] d, input int hold,
                           output logic [15:0] o_data, output logic o_err,
                           output logic o_ovf, output int o_depth);
        logic [15:0] ed, a, b;
        logic        ee, eo;
        int          el, cyc;
        ee = 1'b0; eo = 1'b0; ed = 16'h0; el = 1;
        case (t)
            2'd0: if (model.size() == DEPTH) ee = 1'b1;
                  else begin model.push_back(d); ed = d; end
            2'd1: if (model.size() == 0) ee = 1'b1;
                  else ed = model.pop_back();
            2'd2: if (model.size() < 2 || op > 4'd9) ee = 1'b1;
                  else begin
                      b = model.pop_back();
                      a = model.pop_back();
                      ref_alu(op, a, b, ed, eo);
                      model.push_back(ed);
                      el = 3;
                  end
            default: ee = 1'b1;
        endcase
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_op    = op;
        cmd_data  = d;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        chk("cmd_ready_before_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom);
        cmd_op    = 4'($urandom);
        cmd_data  = 16'($urandom);
        cyc = 1;
        while (!rsp_valid && cyc < 10) begin
            @(posedge clk); #1; cyc++;
        end
        chk("latency", cyc, el);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", rsp_err, ee);
        chk("rsp_overflow", rsp_overflow, eo);
        chk("depth", depth, model.size());
        chk("tos", tos, model_tos());
        chk("cmd_ready_in_resp", cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_data", rsp_data, ed);
            chk("hold_rsp_err", rsp_err, ee);
            chk("hold_rsp_ovf", rsp_overflow, eo);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        o_data  = rsp_data;
        o_err   = rsp_err;
        o_ovf   = rsp_overflow;
        o_depth = int'(depth);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", rsp_valid, 0);
        chk("cmd_ready_after_resp", cmd_ready, 1);
    endtask

    function automatic void add(input logic [1:0] t, input logic [3:0] op,
                                input logic [15:0] d, input logic [15:0] ed,
                                input logic ee, input logic eo, input int dp);
        vec_t v;
        v.t = t; v.op = op; v.d = d;
        v.e_data = ed; v.e_err = ee; v.e_ovf = eo; v.e_depth = dp;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [15:0] od;
        logic        oe, oo;
        int          odp;
        int          r;
        logic [1:0]  t;
        logic [3:0]  op;

        add(0, 0, 16'h0006, 16'h0006, 0, 0, 1);
        add(0, 0, 16'h0009, 16'h0009, 0, 0, 2);
        add(2, 0, 16'h0000, 16'h000F, 0, 0, 1);
        add(1, 0, 16'h0000, 16'h000F, 0, 0, 0);
        add(1, 0, 16'h0000, 16'h0000, 1, 0, 0);
        add(0, 0, 16'hFFFF, 16'hFFFF, 0, 0, 1);
        add(0, 0, 16'h0001, 16'h0001, 0, 0, 2);
        add(2, 0, 16'h0000, 16'h0000, 0, 1, 1);
        add(1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 0, 16'h0000, 16'h0000, 0, 0, 1);
        add(0, 0, 16'h0001, 16'h0001, 0, 0, 2);
        add(2, 1, 16'h0000, 16'hFFFF, 0, 0, 1);
        add(1, 0, 16'h0000, 16'hFFFF, 0, 0, 0);
        add(0, 0, 16'hDEAF, 16'hDEAF, 0, 0, 1);
        add(0, 0, 16'hDEAD, 16'hDEAD, 0, 0, 2);
        add(2, 9, 16'h0000, 16'h0001, 0, 0, 1);
        add(1, 0, 16'h0000, 16'h0001, 0, 0, 0);
        add(0, 0, 16'h0ABC, 16'h0ABC, 0, 0, 1);
        add(0, 0, 16'h0ABC, 16'h0ABC, 0, 0, 2);
        add(2, 7, 16'h0000, 16'h0000, 0, 0, 1);
        add(2, 0, 16'h0000, 16'h0000, 1, 0, 1);
        add(0, 0, 16'h0005, 16'h0005, 0, 0, 2);
        add(2, 4'hC, 16'h0000, 16'h0000, 1, 0, 2);
        add(3, 0, 16'h1111, 16'h0000, 1, 0, 2);
        add(2, 2, 16'h0000, 16'h0000, 0, 0, 1);
        add(1, 0, 16'h0000, 16'h0000, 0, 0, 0);

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 2'd0;
        cmd_op    = 4'd0;
        cmd_data  = 16'h0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_ovf", rsp_overflow, 0);
        chk("reset_depth", depth, 0);
        chk("reset_tos", tos, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_cmd_ready", cmd_ready, 1);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].t, tbl[i].op, tbl[i].d, 0, od, oe, oo, odp);
            chk("vec_data", od, tbl[i].e_data);
            chk("vec_err", oe, tbl[i].e_err);
            chk("vec_ovf", oo, tbl[i].e_ovf);
            chk("vec_depth", odp, tbl[i].e_depth);
        end

        for (int i = 0; i < DEPTH; i++) begin
            run_cmd(0, 0, 16'($urandom), 0, od, oe, oo, odp);
            chk("fill_no_err", oe, 0);
        end
        chk("full_depth", depth, DEPTH);
        run_cmd(0, 0, 16'hBEEF, 0, od, oe, oo, odp);
        chk("overfill_err", oe, 1);
        chk("overfill_depth", odp, DEPTH);
        while (model.size() > 2)
            run_cmd(1, 0, 16'h0, 0, od, oe, oo, odp);
        run_cmd(2, 3, 16'h0, 0, od, oe, oo, odp);
        chk("alu_at_two_depth", odp, 1);

        run_cmd(0, 0, 16'h1357, 0, od, oe, oo, odp);
        run_cmd(2, 4, 16'h0, 5, od, oe, oo, odp);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      t = 2'd0;
            else if (r < 6) t = 2'd1;
            else if (r < 9) t = 2'd2;
            else            t = 2'd3;
            op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 9))
                                             : 4'($urandom_range(10, 15));
            run_cmd(t, op, 16'($urandom), $urandom_range(0, 2),
                    od, oe, oo, odp);
        end

        while (model.size() < 2)
            run_cmd(0, 0, 16'($urandom), 0, od, oe, oo, odp);
        cmd_valid = 1'b1;
        cmd_type  = 2'd2;
        cmd_op    = 4'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("exec_reset_rsp_valid", rsp_valid, 0);
        chk("exec_reset_rsp_data", rsp_data, 0);
        chk("exec_reset_depth", depth, 0);
        chk("exec_reset_tos", tos, 0);
        model.delete();
        cmd_valid = 1'b1;
        cmd_type  = 2'd0;
        cmd_data  = 16'hAAAA;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        @(posedge clk); #1;
        chk("dropped_cmd_depth", depth, 0);
        chk("dropped_cmd_rsp_valid", rsp_valid, 0);
        run_cmd(0, 0, 16'h1234, 0, od, oe, oo, odp);
        chk("post_reset_tos", tos, 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
